uart_tx_feeder: RTL

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_tx_feeder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for uart_tx_feeder.
//
// Contents:
//   SPLIT_EN        1 when UART_TX_FEEDER_SPLIT_EN is defined (send every
//                   byte of a FIFO word), 0 otherwise (send only the low byte)
//   B_SIZE_DEFAULT  default UART frame data width
//   state_t         FSM state encoding plus the ST_* constants
//   num_bytes()     bytes sent per FIFO word for the current build
//
// Build macro: UART_TX_FEEDER_SPLIT_EN
package uart_pkg;

`ifdef UART_TX_FEEDER_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    localparam int B_SIZE_DEFAULT = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_SEND    = 2'd1;
    localparam state_t ST_WAIT_HI = 2'd2;
    localparam state_t ST_WAIT_LO = 2'd3;

    function automatic int num_bytes(input int d_size, input int b_size);
        return SPLIT_EN ? (d_size / b_size) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder -- pops words from a FIFO and hands them to a UART
// transmitter one byte at a time, least-significant byte first.
//
// Parameters:
//   D_SIZE      FIFO word width (multiple of B_SIZE)
//   B_SIZE      UART frame data width
//
// Ports:
//   i_clk       clock (FIFO read domain)
//   i_rstn      asynchronous active-low reset
//   i_empty     FIFO empty flag
//   i_r_data    FIFO read data, valid while i_empty=0
//   o_r_inc     FIFO pop strobe, one cycle per word
//   i_tx_busy   UART transmitter busy
//   o_tx_data   byte presented to the UART, held until the next start strobe
//   o_tx_valid  one-cycle start strobe to the UART
//   o_busy      high whenever the FSM is outside IDLE
//
// Build macro: UART_TX_FEEDER_SPLIT_EN
//   defined   -> every byte of the word is sent (D_SIZE/B_SIZE bytes)
//   undefined -> only the low byte is sent, the byte index does not exist
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a word in the FIFO and an idle transmitter
// SEND    | start strobe cycle (pop strobe too, for the first byte)
// WAIT_HI | waiting for the transmitter to acknowledge with busy=1
// WAIT_LO | waiting for the transmitter to finish the byte (busy=0)
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int D_SIZE = 16,
    parameter int B_SIZE = B_SIZE_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_empty,
    input  logic [D_SIZE-1:0] i_r_data,
    output logic              o_r_inc,
    input  logic              i_tx_busy,
    output logic [B_SIZE-1:0] o_tx_data,
    output logic              o_tx_valid,
    output logic              o_busy
);

    localparam int NUM_BYTES = num_bytes(D_SIZE, B_SIZE);

    if ((B_SIZE < 1) || (D_SIZE < B_SIZE) || ((D_SIZE % B_SIZE) != 0)) begin : g_bad_size
        $error("uart_tx_feeder: D_SIZE must be a non-zero multiple of B_SIZE");
    end

    state_t state;

`ifdef UART_TX_FEEDER_SPLIT_EN
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    logic [D_SIZE-1:0] word;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [B_SIZE-1:0] tx_data;
    logic [B_SIZE-1:0] byte_sel;
    logic              last_byte;

    assign idx_nxt   = idx + 1'b1;
    assign last_byte = (idx == IDX_W'(NUM_BYTES - 1));
    assign o_tx_data = tx_data;

    // Byte for the next SEND; selected one cycle early so o_tx_data can be
    // registered on entry to SEND.
    always_comb begin
        byte_sel = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                byte_sel = word[i*B_SIZE +: B_SIZE];
            end
        end
    end
`else
    // Only the low byte is ever sent, so the word register doubles as the
    // output data register.
    logic [B_SIZE-1:0] word;

    assign o_tx_data = word;

    if (D_SIZE > B_SIZE) begin : g_drop_upper
        logic unused_upper;
        assign unused_upper = ^i_r_data[D_SIZE-1:B_SIZE];
    end
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= ST_IDLE;
            o_busy     <= 1'b0;
            o_tx_valid <= 1'b0;
            o_r_inc    <= 1'b0;
            word       <= '0;
`ifdef UART_TX_FEEDER_SPLIT_EN
            idx        <= '0;
            tx_data    <= '0;
`endif
        end else begin
            o_tx_valid <= 1'b0;
            o_r_inc    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!i_empty && !i_tx_busy) begin
                        state      <= ST_SEND;
                        o_busy     <= 1'b1;
                        o_tx_valid <= 1'b1;
                        o_r_inc    <= 1'b1;
`ifdef UART_TX_FEEDER_SPLIT_EN
                        word       <= i_r_data;
                        idx        <= '0;
                        tx_data    <= i_r_data[B_SIZE-1:0];
`else
                        word       <= i_r_data[B_SIZE-1:0];
`endif
                    end
                end
                ST_SEND: begin
                    state <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (i_tx_busy) begin
                        state <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!i_tx_busy) begin
`ifdef UART_TX_FEEDER_SPLIT_EN
                        if (!last_byte) begin
                            state      <= ST_SEND;
                            idx        <= idx_nxt;
                            tx_data    <= byte_sel;
                            o_tx_valid <= 1'b1;
                        end else begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                        end
`else
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
`endif
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
